// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned MAX_N    = 8;
    localparam int unsigned MAX_OUTS = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // One-hot of sel within the low outs bits; codes >= outs give all-zero.
    function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] sel,
                                                   input int unsigned outs);
        logic [MAX_OUTS-1:0] r;
        r = '0;
        if (32'(sel) < outs) begin
            r[sel] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_n_dwell_counter.sv
// Dwell counter: counts inc cycles modulo DIV and flags the last one with tick.
module dwell_counter #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] dcnt;

    assign tick = inc && (dcnt == W'(DIV - 1));

    // clr takes priority so a load can restart the dwell on any edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
        end else if (clr) begin
            dcnt <= '0;
        end else if (inc) begin
            dcnt <= tick ? '0 : dcnt + W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// N-to-OUTS one-hot decoder with registered outputs, direct load and auto-scan modes.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned OUTS = 8,
    parameter int unsigned DIV  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            load_valid,
    input  logic [N-1:0]    load_idx,
    output logic            load_ready,
    output logic [OUTS-1:0] w,
    output logic [N-1:0]    idx,
    output logic            wrap,
    output logic            err
);

    state_t       state;
    logic         accept;
    logic         legal;
    logic         last;
    logic         clr;
    logic         inc;
    logic         tick;
    logic [N-1:0] nxt_idx;

    // Operating state is decoded from en/mode every cycle
    always_comb begin
        state = IDLE;
        if (en) begin
            state = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end
    end

    assign load_ready = en;
    assign accept     = load_valid && en;
    assign legal      = 32'(load_idx) < OUTS;
    assign last       = idx == N'(OUTS - 1);
    assign nxt_idx    = last ? '0 : idx + N'(1);

    // A load always beats a scan step; an illegal load restarts the dwell only while scanning
    assign clr = accept && (legal || state == SCAN);
    assign inc = (state == SCAN) && !accept;

    dwell_counter #(
        .DIV (DIV)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            w    <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            case (state)
                DIRECT, SCAN: begin
                    if (accept && legal) begin
                        idx <= load_idx;
                        w   <= OUTS'(onehot(MAX_N'(load_idx), OUTS));
                    end else if (accept) begin
                        err <= 1'b1;
                        w   <= OUTS'(onehot(MAX_N'(idx), OUTS));
                    end else if (tick) begin
                        idx  <= nxt_idx;
                        w    <= OUTS'(onehot(MAX_N'(nxt_idx), OUTS));
                        wrap <= last;
                    end else begin
                        w <= OUTS'(onehot(MAX_N'(idx), OUTS));
                    end
                end
                default: begin
                    w <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Randomized and directed checks of two decoder_scan_n configurations against a behavioural model.
module tb_decoder_scan_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load_valid;
    logic [2:0] load_idx;

    logic       ready0, ready1;
    logic [7:0] w0;
    logic [5:0] w1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1, err0, err1;

    int checks = 0;
    int passed = 0;

    // model state per instance: 0 -> OUTS=8/DIV=4, 1 -> OUTS=6/DIV=3
    int m_idx  [2];
    int m_cnt  [2];
    int m_wsel [2];
    int m_wrap [2];
    int m_err  [2];
    int m_outs [2] = '{8, 6};
    int m_div  [2] = '{4, 3};
    int wraps_seen;

    decoder_scan_n #(.N(3), .OUTS(8), .DIV(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .load_valid(load_valid), .load_idx(load_idx), .load_ready(ready0),
        .w(w0), .idx(idx0), .wrap(wrap0), .err(err0)
    );

    decoder_scan_n #(.N(3), .OUTS(6), .DIV(3)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .load_valid(load_valid), .load_idx(load_idx), .load_ready(ready1),
        .w(w1), .idx(idx1), .wrap(wrap1), .err(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_wsel[k] = -1; m_wrap[k] = 0; m_err[k] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held before the edge
    task automatic model_edge(input int k);
        bit acc;
        acc = en && load_valid;
        m_wrap[k] = 0;
        m_err[k]  = 0;
        if (!en) begin
            m_wsel[k] = -1;
        end else if (acc && int'(load_idx) < m_outs[k]) begin
            m_idx[k] = int'(load_idx);
            m_cnt[k] = 0;
            m_wsel[k] = m_idx[k];
        end else if (acc) begin
            m_err[k] = 1;
            if (mode) m_cnt[k] = 0;
            m_wsel[k] = m_idx[k];
        end else begin
            if (mode) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == m_div[k]) begin
                    m_cnt[k] = 0;
                    if (m_idx[k] == m_outs[k] - 1) m_wrap[k] = 1;
                    m_idx[k] = (m_idx[k] + 1) % m_outs[k];
                end
            end
            m_wsel[k] = m_idx[k];
        end
    endtask

    function automatic logic [31:0] exp_w(input int k);
        return (m_wsel[k] < 0) ? 32'd0 : (32'd1 << m_wsel[k]);
    endfunction

    task automatic check_all();
        chk("w0", 32'(w0), exp_w(0));
        chk("idx0", 32'(idx0), 32'(m_idx[0]));
        chk("wrap0", 32'(wrap0), 32'(m_wrap[0]));
        chk("err0", 32'(err0), 32'(m_err[0]));
        chk("w1", 32'(w1), exp_w(1));
        chk("idx1", 32'(idx1), 32'(m_idx[1]));
        chk("wrap1", 32'(wrap1), 32'(m_wrap[1]));
        chk("err1", 32'(err1), 32'(m_err[1]));
        chk("ready", 32'({ready0, ready1}), 32'({en, en}));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        if (wrap0 === 1'b1) wraps_seen++;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1; load_valid = 1'b0; load_idx = 3'd0;
        wraps_seen = 0;
        model_reset();

        // reset held through an edge with en/mode active
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step();
        chk("first_w_after_reset", 32'(w0), 32'h01);

        // direct loads 5 then 2
        mode = 1'b0;
        load_valid = 1'b1; load_idx = 3'd5;
        step();
        chk("direct_load5", 32'(w0), 32'h20);
        load_idx = 3'd2;
        step();
        chk("direct_load2", 32'(w0), 32'h04);
        load_valid = 1'b0;
        repeat (3) step();

        // illegal load on the OUTS=6 instance with idx = 3
        load_valid = 1'b1; load_idx = 3'd3;
        step();
        load_idx = 3'd7;
        step();
        chk("illegal_err", 32'(err1), 32'd1);
        chk("illegal_w", 32'(w1), 32'b001000);
        load_valid = 1'b0;
        step();
        chk("illegal_err_drop", 32'(err1), 32'd0);

        // full scan from 0 through one wrap
        load_valid = 1'b1; load_idx = 3'd0;
        step();
        load_valid = 1'b0; mode = 1'b1;
        wraps_seen = 0;
        repeat (34) step();
        chk("scan_one_wrap", 32'(wraps_seen), 32'd1);

        // load of 1 on the edge that would step 6 -> 7
        for (int i = 0; i < 64 && !(m_idx[0] == 6 && m_cnt[0] == 3); i++) step();
        chk("reach_idx6_dcnt3", 32'(m_idx[0] == 6 && m_cnt[0] == 3), 32'd1);
        load_valid = 1'b1; load_idx = 3'd1;
        step();
        chk("load_wins_idx", 32'(idx0), 32'd1);
        load_valid = 1'b0;
        repeat (4) step();
        chk("step_after_load", 32'(idx0), 32'd2);

        // drop enable at idx 4, then resume
        for (int i = 0; i < 64 && m_idx[0] != 4; i++) step();
        chk("reach_idx4", 32'(idx0), 32'd4);
        en = 1'b0;
        step();
        chk("en_off_w", 32'(w0), 32'd0);
        repeat (2) step();
        en = 1'b1;
        step();
        chk("en_on_w", 32'(w0), 32'h10);
        repeat (6) step();

        // asynchronous reset mid-dwell
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom % 8) != 0;
            mode       = ($urandom % 3) != 0;
            load_valid = ($urandom % 6) == 0;
            load_idx   = 3'($urandom % 8);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
